count_sequence_checker: RTL
===========================

// Module: count_sequence_checker
// PURPOSE
//  Passive observer on the counter interface (clk, reset_n, en, q); consumer end of the stream the counter drives.
//  Predicts each next q from the previous cycle's en/q/DUT reset and flags deviations.
//  Sits beside the counter in benches and in self-checking SoC tops.
//  Reports sync status, mismatch pulses, a saturating error count and wrap events.
// PARAMETERS
//  WIDTH        8   width of observed q
//  SYNC_CYCLES  2   consecutive correct predictions required to leave SYNC (>=1)
//  ERR_CNT_W    16  width of err_cnt; saturates at all-ones
// PORTS
//  clk        in   1          single clock; all logic on posedge
//  reset_n    in   1          synchronous, active-low checker reset
//  arm        in   1          1 = checking enabled; 0 = return to IDLE
//  clr        in   1          1-cycle pulse: clear err_cnt and err_sticky
//  dut_rst_n  in   1          observed counter reset (sync, active-low)
//  en         in   1          observed counter enable
//  q          in   WIDTH      observed counter value
//  in_sync    out  1          1 while state == TRACK
//  mismatch   out  1          1-cycle pulse per wrong sample in TRACK
//  wrap       out  1          1-cycle pulse when q goes all-ones -> 0 with en in TRACK
//  err_sticky out  1          set on first mismatch, held until clr/reset
//  err_cnt    out  ERR_CNT_W  saturating mismatch count
// BEHAVIOUR
//  - reset_n=0 at edge: state=IDLE, all outputs 0, sample regs 0, match_cnt 0.
//  - Sample regs capture q, en, dut_rst_n every edge while arm=1.
//  - Prediction for the current q, from prior-edge samples:
//    dut_rst_n_d=0 -> 0; en_d=1 -> q_d+1 mod 2^WIDTH; else q_d.
//  - States:
//    IDLE : arm=1 -> SYNC (first sample taken, no compare).
//    SYNC : correct -> match_cnt++; match_cnt reaching SYNC_CYCLES -> TRACK.
//           Wrong -> match_cnt=0, no error counted.
//    TRACK: every edge compares. Wrong -> mismatch=1, err_sticky=1, err_cnt+1 (sat).
//           Stays TRACK; next prediction is from the wrong q (no cascade errors).
//    any  : arm=0 -> IDLE next edge; err_cnt/err_sticky retained.
//  - Latency: mismatch/wrap/in_sync are registered and rise on the edge
//    that samples the offending/qualifying q. They are valid the cycle after that edge.
//  - Observed dut_rst_n=0 in TRACK is legal and not an error; the next q is predicted 0.
//  - clr and mismatch on the same edge -> err_cnt=1, err_sticky=1 (mismatch wins).
//  - err_cnt at max + mismatch -> stays max; mismatch still pulses.
//  - wrap only in TRACK, only when q_d=all-ones, en_d=1, dut_rst_n_d=1 and q==0.
// CONFIGURATION
//  CNT_CHK_CAPTURE_EN defined: extra outputs exp_q[WIDTH], got_q[WIDTH].
//    These latch the predicted and observed values of the first mismatch after reset/clr.
//    They hold until clr or reset; reset value 0.
//  Undefined: these ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
//  cnt_chk_pkg: state enum {IDLE,SYNC,TRACK}; function predict_next(q,en,rst_n,width-generic).
//  One sub-module: cnt_chk_sat_counter (ERR_CNT_W, inc, clr, sync reset_n) for err_cnt.
//  Everything else stays in count_sequence_checker.
// TESTING (WIDTH=8, SYNC_CYCLES=2)
//  1 reset_n=0 3 cycles with arm=1 -> all outputs 0, state IDLE.
//  2 arm=1, en=1, q 5,6,7,8 -> in_sync rises on edge 3; mismatch stays 0.
//  3 In TRACK, en=1: q 9 then 11 -> one mismatch pulse, err_cnt=1, err_sticky=1.
//    With CAPTURE_EN: exp_q=10, got_q=11. Next q 12 -> no further mismatch.
//  4 en=1, q 254,255,0 -> one wrap pulse on the edge that samples 0; no mismatch.
//  5 dut_rst_n=0 while q=40, next q=0 -> no error.
//    Then arm=0 -> in_sync=0 next cycle and err_cnt retained.
//  6 ERR_CNT_W=2: force 4 mismatches -> err_cnt=3.
//    Then clr with a simultaneous mismatch -> err_cnt=1.

Source files
------------

// File: rtl/cnt_chk_pkg.sv
// ============================================================================
// Module      : cnt_chk_pkg
// Description : Shared types and the next-value predictor for the counter
//               sequence checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_chk_pkg;

    localparam int c_pred_max_w = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_t;

    // Operands are carried at the widest supported width and masked down to
    // the observed counter width, so one function serves every WIDTH.
    function automatic logic [c_pred_max_w-1:0] predict_next(
        input logic [c_pred_max_w-1:0] q_d,
        input logic                    en_d,
        input logic                    rst_n_d,
        input int unsigned             width
    );
        logic [c_pred_max_w-1:0] mask;
        mask = (width >= c_pred_max_w) ? '1
             : ((c_pred_max_w'(1) << width) - c_pred_max_w'(1));
        if (!rst_n_d)
            return '0;
        else if (en_d)
            return (q_d + c_pred_max_w'(1)) & mask;
        else
            return q_d & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_chk_sat_counter.sv
// ============================================================================
// Module      : cnt_chk_sat_counter
// Description : Saturating event counter; an increment coinciding with clear
//               leaves the count at one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_chk_sat_counter #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] count
);

    logic [ERR_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? ERR_CNT_W'(1) : '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ERR_CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/count_sequence_checker.sv
// ============================================================================
// Module      : count_sequence_checker
// Description : Passive observer of a free-running counter; predicts each q
//               from the previous sample and reports sync, mismatch, wrap and
//               a saturating error count.
//               Optional macro CNT_CHK_CAPTURE_EN adds exp_q/got_q capture of
//               the first mismatch after reset or clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequence_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_CYCLES = 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    input  logic                 clr,
    input  logic                 dut_rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     q,
    output logic                 in_sync,
    output logic                 mismatch,
    output logic                 wrap,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef CNT_CHK_CAPTURE_EN
   ,output logic [WIDTH-1:0]     exp_q
   ,output logic [WIDTH-1:0]     got_q
`endif
);

    localparam int c_mc_w = (SYNC_CYCLES < 2) ? 1 : $clog2(SYNC_CYCLES);
    localparam logic [c_mc_w-1:0] c_sync_last = c_mc_w'(SYNC_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_mc_w-1:0]   r_match_cnt;
    logic [c_mc_w-1:0]   w_match_cnt_next;
    logic [WIDTH-1:0]    r_q_d;
    logic                r_en_d;
    logic                r_rst_n_d;
    logic                r_mismatch;
    logic                r_wrap;
    logic                r_err_sticky;
    logic                w_mismatch_next;
    logic                w_wrap_next;
    logic [WIDTH-1:0]    w_pred;
    logic                w_match;
    logic                w_wrap_cond;

    assign w_pred      = WIDTH'(predict_next(c_pred_max_w'(r_q_d), r_en_d,
                                             r_rst_n_d, WIDTH));
    assign w_match     = (q == w_pred);
    assign w_wrap_cond = (r_q_d == '1) && r_en_d && r_rst_n_d && (q == '0);

    // Samples hold while disarmed so re-arming starts from a fresh capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q_d     <= '0;
            r_en_d    <= 1'b0;
            r_rst_n_d <= 1'b0;
        end else if (arm) begin
            r_q_d     <= q;
            r_en_d    <= en;
            r_rst_n_d <= dut_rst_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_match_cnt <= w_match_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_match_cnt_next = r_match_cnt;
        w_mismatch_next  = 1'b0;
        w_wrap_next      = 1'b0;
        if (!arm) begin
            w_state_next     = IDLE;
            w_match_cnt_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next     = SYNC;
                    w_match_cnt_next = '0;
                end
                SYNC: begin
                    if (!w_match) begin
                        w_match_cnt_next = '0;
                    end else if (r_match_cnt == c_sync_last) begin
                        w_state_next     = TRACK;
                        w_match_cnt_next = '0;
                    end else begin
                        w_match_cnt_next = r_match_cnt + c_mc_w'(1);
                    end
                end
                TRACK: begin
                    w_mismatch_next = !w_match;
                    w_wrap_next     = w_wrap_cond;
                end
                default: begin
                    w_state_next     = IDLE;
                    w_match_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mismatch   <= 1'b0;
            r_wrap       <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_mismatch <= w_mismatch_next;
            r_wrap     <= w_wrap_next;
            if (w_mismatch_next)
                r_err_sticky <= 1'b1;
            else if (clr)
                r_err_sticky <= 1'b0;
        end
    end

    cnt_chk_sat_counter #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_mismatch_next),
        .clr     (clr),
        .count   (err_cnt)
    );

`ifdef CNT_CHK_CAPTURE_EN
    logic [WIDTH-1:0] r_exp_q;
    logic [WIDTH-1:0] r_got_q;

    // A clear on the same edge as a mismatch re-opens the capture window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exp_q <= '0;
            r_got_q <= '0;
        end else if (w_mismatch_next && (!r_err_sticky || clr)) begin
            r_exp_q <= w_pred;
            r_got_q <= q;
        end else if (clr) begin
            r_exp_q <= '0;
            r_got_q <= '0;
        end
    end

    assign exp_q = r_exp_q;
    assign got_q = r_got_q;
`endif

    assign in_sync    = (r_state == TRACK);
    assign mismatch   = r_mismatch;
    assign wrap       = r_wrap;
    assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire
